mem_tagged_responder: RTL and testbench
=======================================

Name: mem_tagged_responder

Overview:
- Memory-side responder for the processor's proc2mem/mem2proc bus. Accepts one command per cycle, issues a transaction tag, and returns load data in order with that tag after a fixed latency.
- Replaces the untimed behavioural memory model with a synthesizable, latency-accurate responder.
- Instruction-side and data-side instances are identical.

Parameters:
- MEM_WORDS, 16384, number of 32-bit words in the backing array.
- MEM_LATENCY, 4, cycles from the acceptance edge to the load-completion edge; legal range 1..32.
- MAX_INFLIGHT, 15, maximum outstanding loads; must be 15 or less, because there are 15 nonzero 4-bit tags.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- proc2mem_command  in  2  bus command: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is treated as BUS_NONE.
- proc2mem_addr  in  32  byte address; bits [1:0] are ignored.
- proc2mem_data  in  32  store data.
- mem2proc_response  out  4  combinational; tag granted this cycle, 0 = not accepted.
- mem2proc_data  out  32  registered; load data, valid when mem2proc_tag != 0.
- mem2proc_tag  out  4  registered; tag of the load completing this cycle, 0 = none.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem2proc_tag=0, mem2proc_data=0.
  - next_tag=1, inflight=0, latency pipeline cleared.
  - Memory array is not reset.
  - Reset mid-operation discards all outstanding loads; no tag for them is ever returned.
- Accept rule, evaluated combinationally each cycle:
  - accept = (cmd is LOAD or STORE) && (addr[31:2] < MEM_WORDS) && !(cmd==LOAD && inflight==MAX_INFLIGHT).
  - mem2proc_response = accept ? next_tag : 0.
  - Rejected commands have no side effects; the requester retries.
- next_tag: advances on every accepted command, LOAD or STORE. Sequence 1,2,...,15,1; 0 is never issued.
- STORE:
  - Array word addr[31:2] is written with proc2mem_data at the acceptance edge.
  - The store consumes a tag but never produces mem2proc_tag.
  - The store is not counted in inflight.
- LOAD:
  - At the acceptance edge, the array word is read and pushed with its tag into the latency pipeline (read-at-accept snapshot).
  - Exactly MEM_LATENCY edges later, mem2proc_tag and mem2proc_data present the tag and data for one cycle, then revert to tag 0 / data 0.
  - Completion order equals acceptance order.
  - Back-to-back loads complete on consecutive cycles.
- inflight: +1 on an accepted LOAD, -1 on a completion edge. Completion and acceptance on the same edge leave it unchanged.
- Full boundary:
  - When inflight==MAX_INFLIGHT, a LOAD is rejected in the same cycle that a completion is being presented; acceptance is decided on the pre-edge count.
  - A STORE is still accepted while full.
- Same-address hazards:
  - A STORE accepted after a LOAD does not alter that load's returned data.
  - A LOAD accepted in the cycle after a STORE to the same address returns the new value.
- Read-write ordering within one edge is not possible, because one command is accepted per cycle.
- Latency pipeline is a MEM_LATENCY-deep shift register of {valid, tag[3:0], data[31:0]}, advancing every cycle; there is no backpressure on the response side.

Decomposition:
- Shared package mem_bus_pkg:
  - enum bus_cmd_t {BUS_NONE, BUS_LOAD, BUS_STORE}.
  - typedef mem_tag_t (logic [3:0]).
  - struct mem_resp_t {valid, tag, data}.
  - constant TAG_NONE=0.
- Sub-module mem_lat_pipe: parameterized-depth valid/tag/data shift register with async active-low reset. It holds the completion timing so the top level contains only the array, the accept logic, the tag counter and the inflight counter.

Test Plan:
- Reset release, BUS_NONE for 10 cycles -> response 0 and tag 0 every cycle; data 0.
- STORE 0xDEADBEEF @0x100, then LOAD @0x100 next cycle -> responses 1 then 2; tag 2 with data 0xDEADBEEF exactly 4 cycles after the LOAD edge, present for one cycle only.
- 16 consecutive LOADs, MEM_LATENCY=32 -> responses 1..15, 16th gets 0. Completions return tags 1..15 in order on consecutive cycles starting 32 cycles after the first accept. A retried 16th LOAD is accepted with tag 1 once the first completion edge has passed.
- LOAD @0x40 (array=0x11), then STORE 0x22 @0x40 next cycle -> load completes with 0x11; a subsequent LOAD returns 0x22.
- LOAD at word index MEM_WORDS -> response 0, next_tag unchanged, no completion.
- Three LOADs issued, rst pulled low for 1 cycle mid-flight -> tag/data 0 immediately (asynchronously); none of the three tags ever appears; next accepted command gets tag 1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared bus command, tag and response types for the proc2mem/mem2proc bus.
package mem_bus_pkg;
   typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_t;
   typedef logic [3:0] mem_tag_t;
   typedef struct packed {
      logic        valid;
      mem_tag_t    tag;
      logic [31:0] data;
   } mem_resp_t;
   localparam mem_tag_t TAG_NONE = 4'd0;
   // Tags cycle 1..15; zero is reserved for "no tag".
   function automatic mem_tag_t tag_advance(input mem_tag_t t);
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction
endpackage

// File: rtl/mem_tagged_responder_if.sv
// mem_tagged_responder_if: proc2mem command bus and mem2proc response bus.
interface mem_tagged_responder_if;
   import mem_bus_pkg::*;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [31:0] proc2mem_data;
   mem_tag_t    mem2proc_response;
   logic [31:0] mem2proc_data;
   mem_tag_t    mem2proc_tag;
   modport master (
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag
   );
   modport slave (
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag
   );
endinterface

// File: rtl/mem_lat_pipe.sv
// mem_lat_pipe: fixed-depth valid/tag/data shift register that times load completions.
module mem_lat_pipe
   import mem_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  mem_resp_t push,
   output mem_resp_t pop
);
   mem_resp_t stage [DEPTH];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= push;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end
   assign pop = stage[DEPTH-1];
endmodule

// File: rtl/mem_tagged_responder.sv
// mem_tagged_responder: tagged memory responder returning in-order load data after a fixed latency.
module mem_tagged_responder
   import mem_bus_pkg::*;
#(
   parameter int MEM_WORDS    = 16384,
   parameter int MEM_LATENCY  = 4,
   parameter int MAX_INFLIGHT = 15
) (
   input logic                     clk,
   input logic                     rst,
   mem_tagged_responder_if.slave   bus
);
   localparam int AW = $clog2(MEM_WORDS);
   logic [31:0] mem [MEM_WORDS];
   mem_tag_t    next_tag;
   logic [3:0]  inflight;
   logic        is_load, is_store, in_range, accept;
   logic [AW-1:0] idx;
   mem_resp_t   push, pop;
   logic        unused_ok;
   assign unused_ok = ^bus.proc2mem_addr[1:0];
   assign is_load  = bus.proc2mem_command == BUS_LOAD;
   assign is_store = bus.proc2mem_command == BUS_STORE;
   assign in_range = bus.proc2mem_addr[31:2] < 30'(MEM_WORDS);
   assign idx      = bus.proc2mem_addr[AW+1:2];
   // Fullness only blocks loads; stores never occupy a completion slot.
   assign accept = (is_load | is_store) & in_range & !(is_load & (inflight == 4'(MAX_INFLIGHT)));
   assign bus.mem2proc_response = accept ? next_tag : TAG_NONE;
   assign push.valid = accept & is_load;
   assign push.tag   = push.valid ? next_tag : TAG_NONE;
   assign push.data  = push.valid ? mem[idx] : '0;
   mem_lat_pipe #(.DEPTH(MEM_LATENCY)) u_pipe (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop)
   );
   assign bus.mem2proc_tag  = pop.tag;
   assign bus.mem2proc_data = pop.data;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         next_tag <= 4'd1;
         inflight <= '0;
      end else begin
         if (accept) next_tag <= tag_advance(next_tag);
         inflight <= inflight + 4'(push.valid) - 4'(pop.valid);
      end
   end
   always_ff @(posedge clk) begin
      if (accept & is_store) mem[idx] <= bus.proc2mem_data;
   end
endmodule

// File: tb/tb_mem_tagged_responder.sv
// tb_mem_tagged_responder: drives two responders (latency 4 and 32) with the same commands
// and checks each against a per-instance schedule of expected completions.
module tb_mem_tagged_responder;
   localparam int WORDS = 16384;
   localparam int MAXC  = 4096;
   localparam int LAT [2] = '{4, 32};
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [1:0]  cmd   = 2'd0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit [3:0]  etag  [2][MAXC];
   bit [31:0] edata [2][MAXC];
   int        infl [2];
   int        ntag [2];
   bit [31:0] mm [int];
   logic [3:0]  rsp  [2];
   logic [3:0]  otag [2];
   logic [31:0] odat [2];
   always #5 clk = ~clk;
   mem_tagged_responder_if if4 ();
   mem_tagged_responder_if if32 ();
   assign if4.proc2mem_command  = cmd;
   assign if4.proc2mem_addr     = addr;
   assign if4.proc2mem_data     = wdata;
   assign if32.proc2mem_command = cmd;
   assign if32.proc2mem_addr    = addr;
   assign if32.proc2mem_data    = wdata;
   assign rsp[0]  = if4.mem2proc_response;
   assign otag[0] = if4.mem2proc_tag;
   assign odat[0] = if4.mem2proc_data;
   assign rsp[1]  = if32.mem2proc_response;
   assign otag[1] = if32.mem2proc_tag;
   assign odat[1] = if32.mem2proc_data;
   mem_tagged_responder #(.MEM_WORDS(WORDS), .MEM_LATENCY(4), .MAX_INFLIGHT(15)) u4 (
      .clk (clk), .rst (rst), .bus (if4.slave)
   );
   mem_tagged_responder #(.MEM_WORDS(WORDS), .MEM_LATENCY(32), .MAX_INFLIGHT(15)) u32 (
      .clk (clk), .rst (rst), .bus (if32.slave)
   );
   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         infl[d] = 0;
         ntag[d] = 1;
         for (int e = cyc; e < cyc + 40 && e < MAXC; e++) begin
            etag[d][e]  = '0;
            edata[d][e] = '0;
         end
      end
   endtask
   // One bus cycle: check the combinational grant and presented completion, then clock.
   task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w, input string nm);
      bit acc [2];
      cmd = c; addr = a; wdata = w;
      #1;
      for (int d = 0; d < 2; d++) begin
         acc[d] = (c == 2'd1 || c == 2'd2) && (a[31:2] < WORDS) && !(c == 2'd1 && infl[d] == 15);
         chk($sformatf("%s_rsp_L%0d", nm, LAT[d]), 32'(rsp[d]), acc[d] ? 32'(ntag[d]) : 32'd0);
         chk($sformatf("%s_tag_L%0d", nm, LAT[d]), 32'(otag[d]), 32'(etag[d][cyc+1]));
         chk($sformatf("%s_data_L%0d", nm, LAT[d]), odat[d], edata[d][cyc+1]);
      end
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (etag[d][cyc] != 0) infl[d]--;
         if (acc[d]) begin
            if (c == 2'd1) begin
               etag[d][cyc+LAT[d]]  = 4'(ntag[d]);
               edata[d][cyc+LAT[d]] = mm[int'(a[31:2])];
               infl[d]++;
            end
            ntag[d] = ntag[d] % 15 + 1;
         end
      end
      if (c == 2'd2 && acc[0]) mm[int'(a[31:2])] = w;
      @(negedge clk);
   endtask
   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) step(2'd0, 32'd0, 32'd0, nm);
   endtask
   initial begin
      logic [31:0] ra;
      logic [1:0]  rc;
      model_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_tag_L%0d", LAT[d]), 32'(otag[d]), 32'd0);
         chk($sformatf("rst_data_L%0d", LAT[d]), odat[d], 32'd0);
      end
      rst = 1'b1;
      idle(10, "idle");
      // Store then dependent load on the next cycle.
      step(2'd2, 32'h100, 32'hDEADBEEF, "st100");
      step(2'd1, 32'h100, 32'd0, "ld100");
      idle(6, "drain1");
      // Fill a pool of words, then 16 back-to-back loads to hit the full limit.
      for (int i = 0; i < 16; i++) step(2'd2, 32'h200 + 32'(4*i), $urandom, "pool_st");
      for (int i = 0; i < 16; i++) step(2'd1, 32'h200 + 32'(4*i), 32'd0, "burst_ld");
      for (int i = 0; i < 40; i++) step(2'd1, 32'h200 + 32'(4*$urandom_range(0, 15)), 32'd0, "retry_ld");
      for (int i = 0; i < 4; i++) step(2'd2, 32'h200 + 32'(4*i), $urandom, "full_st");
      idle(40, "drain2");
      // Load-then-store hazard on one word.
      step(2'd2, 32'h40, 32'h11, "st40a");
      step(2'd1, 32'h40, 32'd0, "ld40a");
      step(2'd2, 32'h40, 32'h22, "st40b");
      step(2'd1, 32'h40, 32'd0, "ld40b");
      idle(35, "drain3");
      // Out-of-range and reserved commands.
      step(2'd1, 32'(WORDS) * 4, 32'd0, "ld_oob");
      step(2'd2, 32'(WORDS) * 4 + 32'd8, 32'h5, "st_oob");
      step(2'd3, 32'h100, 32'd0, "cmd3");
      step(2'd1, 32'h100, 32'd0, "ld_after_oob");
      idle(35, "drain4");
      // Random mix over the known pool.
      for (int i = 0; i < 300; i++) begin
         rc = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 7) == 0) ? 32'(WORDS + $urandom_range(0, 100)) * 4
                                          : 32'h200 + 32'(4*$urandom_range(0, 15));
         step(rc, ra | 32'($urandom_range(0, 3)), $urandom, "rand");
      end
      idle(35, "drain5");
      // Reset while three loads are in flight, one of them being presented.
      step(2'd1, 32'h200, 32'd0, "pre_rst_ld0");
      step(2'd1, 32'h204, 32'd0, "pre_rst_ld1");
      step(2'd1, 32'h208, 32'd0, "pre_rst_ld2");
      step(2'd0, 32'd0, 32'd0, "pre_rst_idle");
      cmd = 2'd0;
      #1;
      chk("pre_rst_tag_L4", 32'(otag[0]), 32'(etag[0][cyc+1]));
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("async_rst_tag_L%0d", LAT[d]), 32'(otag[d]), 32'd0);
         chk($sformatf("async_rst_data_L%0d", LAT[d]), odat[d], 32'd0);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      idle(40, "post_rst");
      step(2'd2, 32'h300, 32'hCAFEF00D, "post_rst_st");
      step(2'd1, 32'h300, 32'd0, "post_rst_ld");
      idle(35, "drain6");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
